// File: rtl/csa_stream_accumulator.sv
// Multi-operand stream adder: operands fold into a carry-save (S, C) pair, and on the
// last operand an iterative carry-propagate phase resolves the pair to binary.
module csa_stream_accumulator #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N+CNT_W-1:0]   out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 overflow
);
    localparam int W = N + CNT_W;

    localparam logic [1:0] ACCUM   = 2'd0;
    localparam logic [1:0] RESOLVE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     s_q, s_d;
    logic [W-1:0]     c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [W-1:0]     d_ext;
    logic             in_hs;

    assign d_ext    = {{CNT_W{1'b0}}, in_data};
    assign in_ready = (state_q == ACCUM) & ~rst;
    assign in_hs    = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                if (in_hs) begin
                    // 3:2 compression of (S, C, operand) keeps the total redundant
                    s_d = s_q ^ c_q ^ d_ext;
                    c_d = ((s_q & c_q) | (s_q & d_ext) | (c_q & d_ext)) << 1;
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (in_last) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                if (c_q == '0) begin
                    state_d = DONE;
                end else begin
                    s_d = s_q ^ c_q;
                    c_d = (s_q & c_q) << 1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs come straight from state; S is already binary once in DONE.
    assign out_valid = (state_q == DONE);
    assign out_sum   = s_q;
    assign out_count = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Bench for csa_stream_accumulator: table vectors, corner-case sequences and
// randomized frames checked against an arithmetic reference model.
module tb_csa_stream_accumulator;
    localparam int N     = 8;
    localparam int CNT_W = 8;
    localparam int W     = N + CNT_W;
    localparam int unsigned MASK = (1 << W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b0;
    logic [N-1:0]     in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic             overflow;
    logic [W-1:0]     out_sum;
    logic [CNT_W-1:0] out_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    csa_stream_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Carry iterations needed to resolve the redundant pair left by a frame.
    function automatic int ref_k(input int unsigned ops[$]);
        int unsigned s = 0, c = 0, d, t;
        int k = 0;
        foreach (ops[i]) begin
            d = ops[i];
            t = s;
            s = (s ^ c ^ d) & MASK;
            c = (((t & c) | (t & d) | (c & d)) << 1) & MASK;
        end
        while (c != 0) begin
            t = s;
            s = (s ^ c) & MASK;
            c = ((t & c) << 1) & MASK;
            k++;
        end
        return k;
    endfunction

    // Called and returns at a falling edge; acc_cyc marks the accepting edge.
    task automatic send_op(input logic [7:0] d, input logic last, input int gap);
        int t = 0;
        logic acc = 1'b0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        forever begin
            acc = in_ready;
            @(negedge clk);
            if (acc) break;
            t++;
            if (t > 500) begin
                chk("send_timeout", acc, 1);
                break;
            end
        end
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(output int sum, output int cnt, output int ovf, output int lat);
        int t = 0;
        while (!out_valid && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) chk("result_timeout", out_valid, 1);
        lat = cyc - acc_cyc + 1;
        sum = out_sum;
        cnt = out_count;
        ovf = overflow;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ready_after_out", in_ready, 1);
        chk("valid_drop_after_out", out_valid, 0);
    endtask

    typedef struct {
        int          n;
        logic [7:0]  op [4];
        int          exp_sum;
        int          exp_cnt;
        int          exp_lat;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int sum, cnt, ovf, lat, n, exp_sum, exp_cnt, exp_ovf, seen;
        int unsigned q[$];
        logic [W-1:0] hold_sum;
        logic [CNT_W-1:0] hold_cnt;

        tbl[0] = '{3, '{8'hFF, 8'hFF, 8'hFF, 8'h00}, 765, 3, 4};
        tbl[1] = '{1, '{8'h5A, 8'h00, 8'h00, 8'h00}, 'h5A, 1, 2};
        tbl[2] = '{4, '{8'h01, 8'h01, 8'h01, 8'h01}, 4, 4, 4};
        tbl[3] = '{2, '{8'h07, 8'h09, 8'h00, 8'h00}, 16, 2, 6};
        tbl[4] = '{2, '{8'h80, 8'h80, 8'h00, 8'h00}, 256, 2, 3};
        tbl[5] = '{1, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 2};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Table vectors with random input gaps
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < tbl[v].n; i++)
                send_op(tbl[v].op[i], i == tbl[v].n - 1, $urandom_range(0, 2));
            wait_result(sum, cnt, ovf, lat);
            chk($sformatf("tbl%0d_sum", v), sum, tbl[v].exp_sum);
            chk($sformatf("tbl%0d_cnt", v), cnt, tbl[v].exp_cnt);
            chk($sformatf("tbl%0d_ovf", v), ovf, 0);
            chk($sformatf("tbl%0d_lat", v), lat, tbl[v].exp_lat);
            release_result();
        end

        // Backpressure: outputs hold, nothing accepted while stalled
        send_op(8'h33, 1'b1, 0);
        wait_result(sum, cnt, ovf, lat);
        chk("bp_sum", sum, 'h33);
        hold_sum = out_sum;
        hold_cnt = out_count;
        in_valid = 1'b1;
        in_data  = 8'h07;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_sum", out_sum, hold_sum);
            chk("bp_hold_cnt", out_count, hold_cnt);
            chk("bp_in_ready", in_ready, 0);
        end
        release_result();
        send_op(8'h07, 1'b0, 0);
        send_op(8'h09, 1'b1, 0);
        wait_result(sum, cnt, ovf, lat);
        chk("bp_next_sum", sum, 16);
        chk("bp_next_cnt", cnt, 2);
        release_result();

        // Randomized frames against the reference model
        for (int f = 0; f < 25; f++) begin
            q = {};
            n = $urandom_range(1, 6);
            exp_sum = 0;
            for (int i = 0; i < n; i++) begin
                q.push_back($urandom_range(0, 255));
                exp_sum += q[i];
                send_op(q[i][7:0], i == n - 1, $urandom_range(0, 2));
            end
            wait_result(sum, cnt, ovf, lat);
            chk("rnd_sum", sum, exp_sum);
            chk("rnd_cnt", cnt, n);
            chk("rnd_ovf", ovf, 0);
            chk("rnd_lat", lat, ref_k(q) + 2);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_result();
        end

        // Operand-count saturation and overflow, then a clean frame
        n = 256;
        exp_cnt = (n > 255) ? 255 : n;
        exp_ovf = (n > 255) ? 1 : 0;
        for (int i = 0; i < n; i++) send_op(8'h01, i == n - 1, 0);
        wait_result(sum, cnt, ovf, lat);
        chk("sat_sum", sum, n);
        chk("sat_cnt", cnt, exp_cnt);
        chk("sat_ovf", ovf, exp_ovf);
        release_result();
        send_op(8'h03, 1'b1, 0);
        wait_result(sum, cnt, ovf, lat);
        chk("post_sat_sum", sum, 3);
        chk("post_sat_ovf", ovf, 0);
        chk("post_sat_cnt", cnt, 1);
        release_result();

        // 255 operands exactly: no overflow
        for (int i = 0; i < 255; i++) send_op(8'h02, i == 254, 0);
        wait_result(sum, cnt, ovf, lat);
        chk("edge255_sum", sum, 510);
        chk("edge255_cnt", cnt, 255);
        chk("edge255_ovf", ovf, 0);
        release_result();

        // Reset during RESOLVE aborts the frame
        send_op(8'hFF, 1'b0, 0);
        send_op(8'h01, 1'b1, 0);
        rst = 1'b1;
        #1;
        chk("abort_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_cnt", out_count, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_result", seen, 0);
        send_op(8'h10, 1'b1, 0);
        wait_result(sum, cnt, ovf, lat);
        chk("abort_next_sum", sum, 'h10);
        chk("abort_next_cnt", cnt, 1);
        release_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
